// File: rtl/mul_share_arb.sv
// Round-robin arbiter feeding a shared unsigned multiplier through a two-stage
// pipeline (operand capture, product register) with output back-pressure.
module mul_share_arb #(
    parameter  int unsigned N_REQ = 4,
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   a_in,
    input  logic [N_REQ*WIDTH-1:0]   b_in,
    output logic [N_REQ-1:0]         gnt,
    output logic                     res_valid,
    output logic [IDW-1:0]           res_id,
    output logic [2*WIDTH-1:0]       res_out,
    input  logic                     res_ready,
    output logic                     busy
);

    logic [IDW-1:0]     ptr_q, ptr_d;

    logic               s1_valid_q;
    logic [WIDTH-1:0]   s1_a_q, s1_b_q;
    logic [IDW-1:0]     s1_id_q;

    logic               s2_valid_q;
    logic [2*WIDTH-1:0] s2_prod_q;
    logic [IDW-1:0]     s2_id_q;

    logic               advance;
    logic               found;
    logic               grant_any;
    logic [IDW-1:0]     win;
    logic [WIDTH-1:0]   sel_a, sel_b;
    logic [2*WIDTH-1:0] prod_c;

    // An empty output stage always accepts, so bubbles fill even while stalled.
    assign advance = !s2_valid_q || res_ready;

    // Winner is the requester with the smallest circular distance from ptr.
    always_comb begin
        int unsigned best_d;
        int unsigned d;
        best_d = N_REQ;
        d      = 0;
        found  = 1'b0;
        win    = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            d = (k >= 32'(ptr_q)) ? (k - 32'(ptr_q)) : (k + N_REQ - 32'(ptr_q));
            if (req[k] && (d < best_d)) begin
                best_d = d;
                found  = 1'b1;
                win    = IDW'(k);
                sel_a  = a_in[k*WIDTH +: WIDTH];
                sel_b  = b_in[k*WIDTH +: WIDTH];
            end
        end
    end

    assign grant_any = found && advance && rst_n;

    always_comb begin
        gnt = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            gnt[k] = grant_any && (32'(win) == k);
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = (32'(win) + 1 == N_REQ) ? '0 : win + IDW'(1);
        end
    end

    assign prod_c = (2*WIDTH)'(s1_a_q) * (2*WIDTH)'(s1_b_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_prod_q  <= '0;
            s2_id_q    <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (advance) begin
                s1_valid_q <= grant_any;
                if (grant_any) begin
                    s1_a_q  <= sel_a;
                    s1_b_q  <= sel_b;
                    s1_id_q <= win;
                end
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_prod_q <= prod_c;
                    s2_id_q   <= s1_id_q;
                end
            end
        end
    end

    assign res_valid = s2_valid_q;
    assign res_id    = s2_id_q;
    assign res_out   = s2_prod_q;
    assign busy      = s1_valid_q || s2_valid_q;

    a_gnt_onehot: assert property (@(posedge clk) $onehot0(gnt));

    a_stall_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (res_valid && !res_ready) |=> (res_valid && $stable(res_out) && $stable(res_id)));

endmodule

// File: tb/tb_mul_share_arb.sv
// Randomised scoreboard bench for mul_share_arb with a cycle-level reference model.
module tb_mul_share_arb;

    localparam int unsigned N = 4;
    localparam int unsigned W = 8;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*W-1:0]  a_in;
    logic [N*W-1:0]  b_in;
    logic [N-1:0]    gnt;
    logic            res_valid;
    logic [1:0]      res_id;
    logic [2*W-1:0]  res_out;
    logic            res_ready;
    logic            busy;

    int errors = 0;
    int checks = 0;

    // Expected results in issue order: {id, product}.
    logic [17:0] sb[$];

    // Reference model state.
    bit m_known = 0;
    bit m_rstd  = 0;
    bit m_s1v   = 0;
    bit m_s2v   = 0;
    int m_ptr   = 0;

    mul_share_arb #(.N_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_out   (res_out),
        .res_ready (res_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, check against the model, then advance the model.
    task automatic step(input logic [N-1:0] r, input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                        input logic rdy, input logic rn);
        bit           adv;
        int           k;
        logic [N-1:0] eg;
        logic [7:0]   ea, eb;
        req = r; a_in = a; b_in = b; res_ready = rdy; rst_n = rn;
        @(negedge clk);
        adv = !m_s2v || rdy;
        k   = -1;
        eg  = '0;
        if (rn && adv) begin
            for (int i = 0; i < N; i++) begin
                if (k < 0 && r[(m_ptr + i) % N]) k = (m_ptr + i) % N;
            end
        end
        if (k >= 0) eg[k] = 1'b1;
        chk("gnt", 32'(gnt), 32'(eg));
        if (m_known) begin
            chk("res_valid", 32'(res_valid), 32'(m_s2v));
            chk("busy", 32'(busy), 32'(m_s1v || m_s2v));
            if (m_rstd) begin
                chk("rst_res_out", 32'(res_out), 32'd0);
                chk("rst_res_id", 32'(res_id), 32'd0);
            end
        end
        if (k >= 0) begin
            ea = a[k*W +: W];
            eb = b[k*W +: W];
            sb.push_back({2'(k), 16'(ea) * 16'(eb)});
        end
        @(posedge clk);
        m_rstd = !rn;
        if (!rn) begin
            m_known = 1;
            m_s1v   = 0;
            m_s2v   = 0;
            m_ptr   = 0;
            sb.delete();
        end else if (adv) begin
            m_s2v = m_s1v;
            m_s1v = (k >= 0);
            if (k >= 0) m_ptr = (k + 1) % N;
        end
        #1;
    endtask

    // Monitor: pops on every accepted product and checks stall stability.
    bit          hold_v = 0;
    logic [15:0] hold_out;
    logic [1:0]  hold_id;
    always @(negedge clk) begin
        logic [17:0] e;
        if (m_known) begin
            if (res_valid && hold_v) begin
                chk("hold_out", 32'(res_out), 32'(hold_out));
                chk("hold_id", 32'(res_id), 32'(hold_id));
            end
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: got product id=%0d out=%0h expected none", res_id, res_out);
                end else begin
                    e = sb.pop_front();
                    chk("res_id", 32'(res_id), 32'(e[17:16]));
                    chk("res_out", 32'(res_out), 32'(e[15:0]));
                end
            end
            hold_v   = res_valid && !res_ready && rst_n;
            hold_out = res_out;
            hold_id  = res_id;
        end
    end

    initial begin
        logic [N*W-1:0] ra, rb;
        req = '0; a_in = '0; b_in = '0; res_ready = 1'b1; rst_n = 1'b0;
        @(posedge clk);
        #1;
        // Reset with all requests high.
        repeat (3) step(4'hF, '0, '0, 1'b1, 1'b0);
        step(4'h0, '0, '0, 1'b1, 1'b1);
        // Single request from requester 2: 12*11.
        step(4'b0100, 32'h000C_0000, 32'h000B_0000, 1'b1, 1'b1);
        repeat (3) step(4'h0, '0, '0, 1'b1, 1'b1);
        // All requesters, full throughput, starting from ptr 0.
        step(4'h0, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            ra = $urandom; rb = $urandom;
            step(4'hF, ra, rb, 1'b1, 1'b1);
        end
        // Operand extremes.
        step(4'b1010, 32'h0000_FF00, 32'hA500_FF00, 1'b1, 1'b1);
        step(4'b1000, 32'h0000_FF00, 32'hA500_FF00, 1'b1, 1'b1);
        repeat (3) step(4'h0, '0, '0, 1'b1, 1'b1);
        // Back-pressure then drain.
        for (int i = 0; i < 4; i++) begin
            ra = $urandom; rb = $urandom;
            step(4'hF, ra, rb, 1'b0, 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            ra = $urandom; rb = $urandom;
            step(4'h0, ra, rb, 1'b1, 1'b1);
        end
        // Reset one cycle after a grant.
        step(4'b0010, 32'h0000_3300, 32'h0000_4400, 1'b1, 1'b1);
        step(4'h0, '0, '0, 1'b1, 1'b0);
        step(4'hF, 32'h0000_0007, 32'h0000_0009, 1'b1, 1'b1);
        repeat (3) step(4'h0, '0, '0, 1'b1, 1'b1);
        // Random traffic with random stalls and occasional resets.
        for (int i = 0; i < 400; i++) begin
            ra = $urandom; rb = $urandom;
            step(4'($urandom), ra, rb, 1'($urandom_range(0, 9) < 7),
                 1'($urandom_range(0, 99) != 0));
        end
        repeat (6) step(4'h0, '0, '0, 1'b1, 1'b1);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
